share_encoder_3: RTL and testbench
==================================

// Module: share_encoder_3
// PURPOSE
//  Masking front-end for the second-order d+1 datapath: splits each unmasked WIDTH-bit word into three
//  Boolean shares (share0 ^ share1 ^ share2 == data), drawing fresh masks from an internal reseedable LFSR.
//  It is the inverse of the share-recombining XOR at the datapath output.
//  Sits between the plaintext/key loader and the masked AES round input; valid/ready on both sides.
// PARAMETERS
//  WIDTH         8    bits per data word and per share
//  LFSR_W        32   PRNG state width; must be >= 2*WIDTH
//  WARMUP_CYCLES 16   LFSR advance cycles after every seed load before input is accepted
// PORTS
//  clk          in   1             single clock, rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  seed_valid   in   1             load seed this cycle
//  seed         in   LFSR_W        PRNG seed; all-zero seed is ignored
//  in_valid     in   1             unmasked word present
//  in_ready     out  1             block accepts in_data this cycle
//  in_data      in   WIDTH         unmasked word
//  out_valid    out  1             shares present
//  out_ready    in   1             consumer takes shares this cycle
//  out_shares   out  3*WIDTH       {share2, share1, share0}, share0 in [WIDTH-1:0]
//  seeded       out  1             FSM in READY
// BEHAVIOUR
//  Reset (async, rst_n=0): state=UNSEEDED, lfsr=0, warm counter=0, out_valid=0, out_shares=0, in_ready=0, seeded=0.
//  FSM: UNSEEDED --seed_valid & seed!=0--> WARMUP --counter==WARMUP_CYCLES-1--> READY.
//   - In any state, seed_valid & seed!=0: lfsr<=seed, counter<=0, state<=WARMUP (reseed restarts warmup).
//   - seed_valid & seed==0: no effect in any state.
//   - WARMUP: lfsr advances 2*WIDTH bit-steps per cycle, counter increments; in_ready=0.
//  in_ready = (state==READY) & (~out_valid | out_ready). Combinational, no dependence on in_valid.
//  Accept (in_valid & in_ready): m1=lfsr[WIDTH-1:0], m2=lfsr[2*WIDTH-1:WIDTH];
//   share0<=in_data^m1^m2, share1<=m1, share2<=m2; out_valid<=1. Same edge: lfsr advances 2*WIDTH bit-steps.
//   Each accepted word therefore uses disjoint, never-reused mask bits.
//  Latency 1 cycle, throughput 1 word/cycle with out_ready held high.
//  LFSR advances only on accept or in WARMUP; it holds in READY when idle.
//  Output: out_valid & ~out_ready -> out_shares and out_valid hold stable.
//   out_ready & ~accept -> out_valid<=0; out_shares keep their last value.
//  Reseed while a word is pending: the pending shares stay valid and deliverable.
//   No new accept until READY is re-entered.
//  LFSR: Fibonacci, polynomial x^32+x^22+x^2+x+1 for LFSR_W=32.
//   One bit-step: new_bit = s[31]^s[21]^s[1]^s[0], s <= {s[LFSR_W-2:0], new_bit}. Never reaches zero from a nonzero seed.
//  No combinational path from in_data to any output; share0 is a register output only.
//  (No glitch-combining of data with both masks outside the register.)
// STRUCTURE
//  masking_pkg: LFSR_W default, tap positions, state encoding (UNSEEDED=2'd0, WARMUP=2'd1, READY=2'd2).
//  Sub-module lfsr_advance #(LFSR_W, STEPS=2*WIDTH): purely combinational unrolled STEPS-bit-step next-state function.
//   Instantiated once; its output feeds both the accept path and the warmup path.
//  Top: FSM + warm counter ($clog2(WARMUP_CYCLES) bits), lfsr register, output register, handshake logic.
// TESTING (bench carries a bit-exact LFSR model; all checks every cycle)
//  1 Reset values: rst_n=0 mid-run, any inputs -> next sample out_valid=0, out_shares=0, in_ready=0, seeded=0.
//  2 Seed and warmup: seed=32'h0000_0001 at cycle t -> in_ready=0 for cycles t+1..t+16, in_ready=1 at t+17.
//    Then in_data=8'hA5 -> one cycle later XOR of the shares = 8'hA5, share1/share2 = model mask bytes.
//  3 Zero seed: seed_valid with seed=0 while UNSEEDED -> stays UNSEEDED, in_ready=0 for 100 cycles.
//  4 Backpressure: stream 8'h00..8'h0F, out_ready toggled 1010...
//    -> no word lost or duplicated, shares stable while stalled, every XOR equals its input.
//    -> masks never repeat against the model sequence.
//  5 Reseed mid-stream: pending word held with out_ready=0, seed=32'hDEAD_BEEF
//    -> pending shares unchanged and delivered, in_ready=0 for 16 cycles, then masks follow the new seed.
//  6 Async reset during WARMUP (rst_n low between clock edges) -> outputs clear immediately.
//    After release, UNSEEDED until a new nonzero seed arrives.

Source files
------------

// File: rtl/share_encoder_3_pkg.sv
// share_encoder_3_pkg: shared PRNG defaults, LFSR taps and encoder FSM state encoding
package share_encoder_3_pkg;

    localparam int LFSR_W_DEF = 32;

    // Feedback taps below the MSB for x^32+x^22+x^2+x+1 (the MSB tap is always LFSR_W-1)
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        WARMUP   = 2'd1,
        READY    = 2'd2
    } state_t;

endpackage

// File: rtl/share_encoder_3_lfsr.sv
// lfsr_advance: unrolled multi-step next-state function of the Fibonacci mask LFSR
module lfsr_advance
    import share_encoder_3_pkg::*;
#(
    parameter int LFSR_W = LFSR_W_DEF,
    parameter int STEPS  = 16
) (
    input  logic [LFSR_W-1:0] cur,
    output logic [LFSR_W-1:0] nxt
);

    logic [LFSR_W-1:0] s;

    // Shift in one feedback bit per step, STEPS times, all within one cycle
    always_comb begin
        s = cur;
        for (int i = 0; i < STEPS; i++)
            s = {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
        nxt = s;
    end

endmodule

// File: rtl/share_encoder_3.sv
// share_encoder_3: splits each word into three Boolean shares using fresh LFSR masks
module share_encoder_3
    import share_encoder_3_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int LFSR_W        = LFSR_W_DEF,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_valid,
    input  logic [LFSR_W-1:0]  seed,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3*WIDTH-1:0] out_shares,
    output logic               seeded
);

    localparam int CW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  m1;
    logic [WIDTH-1:0]  m2;
    logic              seed_load;
    logic              accept;

    // One shared advance block serves both warmup stepping and per-word mask consumption
    lfsr_advance #(
        .LFSR_W(LFSR_W),
        .STEPS (2 * WIDTH)
    ) u_adv (
        .cur(lfsr),
        .nxt(lfsr_nxt)
    );

    assign m1        = lfsr[WIDTH-1:0];
    assign m2        = lfsr[2*WIDTH-1:WIDTH];
    assign seed_load = seed_valid && (seed != '0);
    assign in_ready  = (state == READY) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign seeded    = (state == READY);

    // FSM, warmup counter and PRNG state; a nonzero seed restarts warmup from any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNSEEDED;
            lfsr  <= '0;
            cnt   <= '0;
        end else if (seed_load) begin
            state <= WARMUP;
            lfsr  <= seed;
            cnt   <= '0;
        end else if (state == WARMUP) begin
            lfsr <= lfsr_nxt;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(WARMUP_CYCLES - 1))
                state <= READY;
        end else if (accept) begin
            lfsr <= lfsr_nxt;
        end
    end

    // Output register: data meets both masks only at the register input, shares hold under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_shares <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_shares <= {m2, m1, in_data ^ m1 ^ m2};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_share_encoder_3.sv
// tb_share_encoder_3: directed scenario bench for the three-share masking encoder
module tb_share_encoder_3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_valid;
    logic [31:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_shares;
    logic        seeded;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_lfsr;

    share_encoder_3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_valid(seed_valid),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_shares(out_shares),
        .seeded    (seeded)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16 single bit-steps of x^32+x^22+x^2+x+1
    function automatic logic [31:0] adv(input logic [31:0] s);
        for (int i = 0; i < 16; i++)
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        return s;
    endfunction

    function automatic logic [31:0] adv_n(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++)
            s = adv(s);
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; seed_valid = 1'b1; seed = 32'h5; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_shares !== 24'h0) begin n_bad++; $display("FAIL reset_out_shares: got %h want 000000", out_shares); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (seeded !== 1'b0) begin n_bad++; $display("FAIL reset_seeded: got %b want 0", seeded); end
        rst_n = 1'b1; seed_valid = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_zero_seed;
        seed_valid = 1'b1; seed = 32'h0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        tick();
        seed_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || seeded !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_seed cyc %0d: got rdy=%b seeded=%b ov=%b want 0 0 0", c, in_ready, seeded, out_valid);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_seed_warmup;
        out_ready = 1'b1; in_valid = 1'b0;
        seed_valid = 1'b1; seed = 32'h0000_0001;
        tick();
        seed_valid = 1'b0;
        m_lfsr = adv_n(32'h0000_0001, 16);
        for (int c = 1; c <= 16; c++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL warmup_in_ready t+%0d: got %b want 0", c, in_ready); end
            tick();
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL warmup_done_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (seeded !== 1'b1) begin n_bad++; $display("FAIL warmup_done_seeded: got %b want 1", seeded); end
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL a5_out_valid: got %b want 1", out_valid); end
        n_cmp++; if ((out_shares[7:0] ^ out_shares[15:8] ^ out_shares[23:16]) !== 8'hA5) begin
            n_bad++; $display("FAIL a5_xor: got %h want a5", out_shares[7:0] ^ out_shares[15:8] ^ out_shares[23:16]); end
        n_cmp++; if (out_shares[23:8] !== m_lfsr[15:0]) begin
            n_bad++; $display("FAIL a5_masks: got %h want %h", out_shares[23:8], m_lfsr[15:0]); end
        m_lfsr = adv(m_lfsr);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL a5_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [7:0]  idx;
        logic [7:0]  exp_data;
        logic        exp_ov;
        logic        exp_rdy;
        logic [23:0] exp_sh;
        logic        dup;
        logic [15:0] used[$];
        int          delivered;
        idx = 8'h00; exp_data = 8'h00; exp_ov = 1'b0; exp_sh = 24'h0; delivered = 0;
        for (int cyc = 0; cyc < 100 && delivered < 16; cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid = (idx < 8'd16);
            in_data = idx;
            #1;
            exp_rdy = !exp_ov || out_ready;
            n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy); end
            n_cmp++; if (out_valid !== exp_ov) begin n_bad++; $display("FAIL bp_out_valid cyc %0d: got %b want %b", cyc, out_valid, exp_ov); end
            if (exp_ov) begin
                n_cmp++; if (out_shares !== exp_sh) begin n_bad++; $display("FAIL bp_shares cyc %0d: got %h want %h", cyc, out_shares, exp_sh); end
            end
            if (exp_ov && out_ready) begin
                n_cmp++; if ((out_shares[7:0] ^ out_shares[15:8] ^ out_shares[23:16]) !== exp_data) begin
                    n_bad++; $display("FAIL bp_xor word %0d: got %h want %h", delivered, out_shares[7:0] ^ out_shares[15:8] ^ out_shares[23:16], exp_data); end
                dup = 1'b0;
                foreach (used[k]) if (used[k] == out_shares[23:8]) dup = 1'b1;
                n_cmp++; if (dup) begin n_bad++; $display("FAIL bp_mask_repeat word %0d: got %h want unique", delivered, out_shares[23:8]); end
                used.push_back(out_shares[23:8]);
                delivered++;
            end
            if (in_valid && exp_rdy) begin
                exp_sh = {m_lfsr[15:8], m_lfsr[7:0], idx ^ m_lfsr[7:0] ^ m_lfsr[15:8]};
                exp_data = idx;
                exp_ov = 1'b1;
                m_lfsr = adv(m_lfsr);
                idx++;
            end else if (out_ready) begin
                exp_ov = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (delivered != 16) begin n_bad++; $display("FAIL bp_delivered: got %0d want 16", delivered); end
        tick();
    endtask

    task automatic test_reseed;
        logic [23:0] exp_sh;
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rs_pre_ready: got %b want 1", in_ready); end
        exp_sh = {m_lfsr[15:8], m_lfsr[7:0], 8'h3C ^ m_lfsr[7:0] ^ m_lfsr[15:8]};
        tick();
        in_valid = 1'b0; seed_valid = 1'b1; seed = 32'hDEAD_BEEF;
        tick();
        seed_valid = 1'b0;
        m_lfsr = adv_n(32'hDEAD_BEEF, 16);
        for (int k = 0; k < 16; k++) begin
            out_ready = (k == 3);
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rs_in_ready k=%0d: got %b want 0", k, in_ready); end
            n_cmp++; if (out_valid !== (k <= 3)) begin n_bad++; $display("FAIL rs_out_valid k=%0d: got %b want %b", k, out_valid, k <= 3); end
            n_cmp++; if (out_shares !== exp_sh) begin n_bad++; $display("FAIL rs_shares k=%0d: got %h want %h", k, out_shares, exp_sh); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rs_ready_again: got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rs_new_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_shares !== {m_lfsr[15:8], m_lfsr[7:0], 8'h5A ^ m_lfsr[7:0] ^ m_lfsr[15:8]}) begin
            n_bad++; $display("FAIL rs_new_shares: got %h want %h", out_shares, {m_lfsr[15:8], m_lfsr[7:0], 8'h5A ^ m_lfsr[7:0] ^ m_lfsr[15:8]}); end
        m_lfsr = adv(m_lfsr);
        tick();
    endtask

    task automatic test_async_reset;
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; seed_valid = 1'b1; seed = 32'h1234_5678;
        tick();
        seed_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pending: got %b want 1", out_valid); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_shares !== 24'h0) begin n_bad++; $display("FAIL ar_out_shares: got %h want 000000", out_shares); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ar_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (seeded !== 1'b0) begin n_bad++; $display("FAIL ar_seeded: got %b want 0", seeded); end
        repeat (2) tick();
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_cmp++; if (in_ready !== 1'b0 || seeded !== 1'b0) begin
                n_bad++; $display("FAIL ar_unseeded cyc %0d: got rdy=%b seeded=%b want 0 0", c, in_ready, seeded); end
        end
        seed_valid = 1'b1; seed = 32'h0000_0001;
        tick();
        seed_valid = 1'b0;
        m_lfsr = adv_n(32'h0000_0001, 16);
        repeat (16) tick();
        n_cmp++; if (seeded !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL ar_reseeded: got seeded=%b rdy=%b want 1 1", seeded, in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_shares !== {m_lfsr[15:8], m_lfsr[7:0], 8'hC3 ^ m_lfsr[7:0] ^ m_lfsr[15:8]}) begin
            n_bad++; $display("FAIL ar_first_word: got %h want %h", out_shares, {m_lfsr[15:8], m_lfsr[7:0], 8'hC3 ^ m_lfsr[7:0] ^ m_lfsr[15:8]}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_seed();
        test_seed_warmup();
        test_backpressure();
        test_reseed();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
